// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: PS/2 set-2 receiver that keeps a pressed-key map, the last changed code,
// an event strobe and a frame error strobe; handles E0/F0 prefixes and frame timeouts.
module ps2_key_decoder #(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 200000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ps2_clk,
    input  logic         ps2_data,
    output logic [511:0] key_down,
    output logic [8:0]   last_change,
    output logic         been_ready,
    output logic         frame_err
);
    typedef enum logic [1:0] {IDLE, SHIFT, STOP, DECODE} state_t;
    state_t state, state_n;
    logic [1:0]  ck_s, dt_s;
    logic        fclk, fclk_d, fall, dat, tout, err, ok, ext, brk;
    logic [3:0]  fcnt, bitcnt;
    logic [9:0]  sr;
    logic [17:0] tcnt;
    logic [7:0]  b;

    assign dat  = dt_s[1];
    assign fall = fclk_d & ~fclk;
    assign b    = sr[8:1];
    assign tout = (state == SHIFT || state == STOP) && !fall && tcnt == 18'(TIMEOUT - 1);

    // Sync flops and filtered clock idle high so reset release never looks like a fall
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ck_s   <= 2'b11;
            dt_s   <= 2'b11;
            fclk   <= 1'b1;
            fclk_d <= 1'b1;
            fcnt   <= '0;
        end else begin
            ck_s   <= {ck_s[0], ps2_clk};
            dt_s   <= {dt_s[0], ps2_data};
            fclk_d <= fclk;
            if (ck_s[1] == fclk) fcnt <= '0;
            else if (fcnt == 4'(FILTER_LEN - 1)) begin
                fclk <= ck_s[1];
                fcnt <= '0;
            end else fcnt <= fcnt + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    // sr holds start at [0], data at [8:1] and parity at [9] when the stop bit arrives
    always_comb begin
        state_n = state;
        err     = 1'b0;
        ok      = 1'b0;
        case (state)
            IDLE:  state_n = (fall && !dat) ? SHIFT : IDLE;
            SHIFT: begin
                err     = tout;
                state_n = tout ? IDLE : (fall && bitcnt == 4'd8) ? STOP : SHIFT;
            end
            STOP: begin
                ok      = fall && dat && !sr[0] && ^sr[9:1];
                err     = tout || (fall && !ok);
                state_n = ok ? DECODE : err ? IDLE : STOP;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr          <= '0;
            bitcnt      <= '0;
            tcnt        <= '0;
            ext         <= 1'b0;
            brk         <= 1'b0;
            key_down    <= '0;
            last_change <= '0;
            been_ready  <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            been_ready <= 1'b0;
            frame_err  <= err;
            if (fall && (state == IDLE || state == SHIFT)) sr <= {dat, sr[9:1]};
            bitcnt <= (state == IDLE) ? '0 : bitcnt + 4'(state == SHIFT && fall);
            tcnt   <= (state == IDLE || state == DECODE || fall) ? '0 : tcnt + 18'(tcnt != 18'(TIMEOUT));
            if (err) begin
                ext <= 1'b0;
                brk <= 1'b0;
            end
            // The event is committed on the stop-bit fall so it is visible during DECODE
            if (ok) begin
                if (b == 8'hE0) ext <= 1'b1;
                else if (b == 8'hF0) brk <= 1'b1;
                else begin
                    key_down[{ext, b}] <= ~brk;
                    last_change        <= {ext, b};
                    been_ready         <= 1'b1;
                    ext                <= 1'b0;
                    brk                <= 1'b0;
                end
            end
        end
    end
endmodule
